// File: rtl/wb_spi_target.sv
// wb_spi_target: SPI mode-0 target (MSB first, 8-bit frames) with RX/TX byte FIFOs behind a Wishbone port.
// Define SPI_TARGET_IRQ_EN to build the irq_o output and the IRQ_EN register at word address 2.

module wb_spi_target_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end
endmodule

module wb_spi_target #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic [1:0]  adr_i,
    input  logic        we_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    input  logic        sck,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
`ifdef SPI_TARGET_IRQ_EN
    ,
    output logic        irq_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [2:0]  meta_reg;
    logic [2:0]  sync_reg;
    logic        sck_d_reg;
    logic        ss_d_reg;
    logic        sck_s, ss_s, mosi_s;
    logic        ss_fall, ss_rise, spi_rise, spi_fall;

    logic        frame_active_reg;
    logic        miso_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  rx_sh_reg;
    logic [7:0]  tx_sh_reg;
    logic        ack_reg;
    logic        ovr_reg, udr_reg;
    logic        ovr_next, udr_next;

    logic        tx_load, tx_push, tx_empty, tx_full;
    logic [7:0]  tx_head, tx_load_byte;
    logic [AW:0] tx_count_unused;
    logic        rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]  rx_byte, rx_head;
    logic [AW:0] rx_count;
    logic [31:0] rx_count_wide;
    logic [7:0]  rx_count_sat;

    logic        wb_acc, wb_wr, wb_rd, w1c;
    logic [31:0] status_word;
    logic [31:0] irq_en_rd;
    logic        bits_unused;

    assign bits_unused = ^{dat_i[31:8], sel_i[3:1]};

    // The ss stages reset to "asserted" so a frame already in progress at reset
    // produces no falling edge and is ignored until ss goes high and low again.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            meta_reg  <= '0;
            sync_reg  <= '0;
            sck_d_reg <= 1'b0;
            ss_d_reg  <= 1'b0;
        end else begin
            meta_reg  <= {ss, sck, mosi};
            sync_reg  <= meta_reg;
            sck_d_reg <= sck_s;
            ss_d_reg  <= ss_s;
        end
    end

    assign {ss_s, sck_s, mosi_s} = sync_reg;
    assign ss_fall  = ss_d_reg & ~ss_s;
    assign ss_rise  = ~ss_d_reg & ss_s;
    assign spi_rise = frame_active_reg & ~ss_rise & sck_s & ~sck_d_reg;
    assign spi_fall = frame_active_reg & ~ss_rise & ~sck_s & sck_d_reg;

    assign tx_load      = ss_fall | (spi_fall & (bit_cnt_reg == 3'd0));
    assign tx_load_byte = tx_empty ? FILL_BYTE : tx_head;
    assign rx_byte      = {rx_sh_reg[6:0], mosi_s};
    assign rx_push      = spi_rise & (bit_cnt_reg == 3'd7);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            frame_active_reg <= 1'b0;
            bit_cnt_reg      <= '0;
            rx_sh_reg        <= '0;
            tx_sh_reg        <= '0;
            miso_reg         <= 1'b1;
        end else if (ss_rise) begin
            frame_active_reg <= 1'b0;
            bit_cnt_reg      <= '0;
            miso_reg         <= 1'b1;
        end else if (ss_fall) begin
            frame_active_reg <= 1'b1;
            bit_cnt_reg      <= '0;
            tx_sh_reg        <= tx_load_byte;
            miso_reg         <= tx_load_byte[7];
        end else if (spi_rise) begin
            rx_sh_reg   <= rx_byte;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end else if (spi_fall) begin
            if (bit_cnt_reg == 3'd0) begin
                tx_sh_reg <= tx_load_byte;
                miso_reg  <= tx_load_byte[7];
            end else begin
                tx_sh_reg <= {tx_sh_reg[6:0], 1'b0};
                miso_reg  <= tx_sh_reg[6];
            end
        end
    end

    assign miso    = miso_reg;
    assign miso_oe = frame_active_reg;

    // Register side effects happen only in the acknowledge cycle.
    assign wb_acc  = ack_reg & cyc_i & stb_i;
    assign wb_wr   = wb_acc & we_i;
    assign wb_rd   = wb_acc & ~we_i;
    assign tx_push = wb_wr & (adr_i == 2'd0) & sel_i[0];
    assign rx_pop  = wb_rd & (adr_i == 2'd0);
    assign w1c     = wb_wr & (adr_i == 2'd1);

    wb_spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (tx_push),
        .din   (dat_i[7:0]),
        .pop   (tx_load),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count_unused)
    );

    wb_spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rx_push),
        .din   (rx_byte),
        .pop   (rx_pop),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    // A new event wins over a clear landing in the same cycle.
    always_comb begin
        ovr_next = (ovr_reg & ~(w1c & dat_i[4])) | (rx_push & rx_full);
        udr_next = (udr_reg & ~(w1c & dat_i[5])) | (tx_load & tx_empty);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_reg <= 1'b0;
            ovr_reg <= 1'b0;
            udr_reg <= 1'b0;
        end else begin
            ack_reg <= ack_reg ? 1'b0 : (cyc_i & stb_i);
            ovr_reg <= ovr_next;
            udr_reg <= udr_next;
        end
    end

    assign ack_o = ack_reg;

`ifdef SPI_TARGET_IRQ_EN
    logic [2:0] irq_en_reg;
    logic       irq_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            irq_en_reg <= '0;
            irq_reg    <= 1'b0;
        end else begin
            if (wb_wr && (adr_i == 2'd2)) irq_en_reg <= dat_i[2:0];
            irq_reg <= |(irq_en_reg & {udr_reg, ovr_reg, ~rx_empty});
        end
    end

    assign irq_o     = irq_reg;
    assign irq_en_rd = {29'd0, irq_en_reg};
`else
    assign irq_en_rd = '0;
`endif

    assign rx_count_wide = 32'(rx_count);
    assign rx_count_sat  = (rx_count_wide > 32'd255) ? 8'hFF : rx_count_wide[7:0];
    assign status_word   = {16'd0, rx_count_sat, 1'b0, frame_active_reg, udr_reg, ovr_reg,
                            tx_full, tx_empty, rx_full, rx_empty};

    always_comb begin
        dat_o = '0;
        case (adr_i)
            2'd0:    dat_o = rx_empty ? 32'd0 : {24'd0, rx_head};
            2'd1:    dat_o = status_word;
            2'd2:    dat_o = irq_en_rd;
            default: dat_o = '0;
        endcase
    end
endmodule
